// File: rtl/execute_mc_if.sv
// Handshake and operand/result bundle for execute_mc.
// slave = execute stage, master = decode / downstream driver.
interface execute_mc_if #(
  parameter int XLEN = 32,
  parameter int RA_W = 5
);
  logic            stall_in;
  logic            flush_in;
  logic            valid_in;
  logic            ready_out;
  logic [6:0]      opcode_in;
  logic [2:0]      funct3_in;
  logic [6:0]      funct7_in;
  logic [XLEN-1:0] rs1_value_in;
  logic [XLEN-1:0] rs2_value_in;
  logic [XLEN-1:0] imm_value_in;
  logic [XLEN-1:0] pc_in;
  logic [RA_W-1:0] rd_in;
  logic            valid_out;
  logic            rd_write;
  logic [RA_W-1:0] rd_out;
  logic [XLEN-1:0] result_out;
  logic [XLEN-1:0] lsu_addr_out;
  logic            branch_taken_out;
  logic [XLEN-1:0] branch_pc_out;
  logic            busy_out;

  modport slave (
    input  stall_in, flush_in, valid_in,
    input  opcode_in, funct3_in, funct7_in,
    input  rs1_value_in, rs2_value_in,
    input  imm_value_in, pc_in, rd_in,
    output ready_out, valid_out, rd_write,
    output rd_out, result_out, lsu_addr_out,
    output branch_taken_out, branch_pc_out,
    output busy_out
  );

  modport master (
    output stall_in, flush_in, valid_in,
    output opcode_in, funct3_in, funct7_in,
    output rs1_value_in, rs2_value_in,
    output imm_value_in, pc_in, rd_in,
    input  ready_out, valid_out, rd_write,
    input  rd_out, result_out, lsu_addr_out,
    input  branch_taken_out, branch_pc_out,
    input  busy_out
  );
endinterface

// File: rtl/execute_mc.sv
// Multi-cycle execute stage: 1-cycle ALU/branch path,
// iterative shift-add MUL (low half), valid/ready + flush.
module execute_mc #(
  parameter int XLEN   = 32,
  parameter bit MUL_EN = 1'b1,
  parameter int RA_W   = 5
) (
  input logic         req,
  input logic         rst,
  execute_mc_if.slave io
);
  localparam int CW = $clog2(XLEN);
  localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_BR    = 7'b1100011;
  localparam logic [6:0] OPC_LOAD  = 7'b0000011;
  localparam logic [6:0] OPC_STORE = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM = 7'b0010011;
  localparam logic [6:0] OPC_OP    = 7'b0110011;

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0] mcand_q, mcand_d;
  logic [XLEN-1:0] mplier_q, mplier_d;
  logic            valid_q, valid_d;
  logic            wr_q, wr_d;
  logic [RA_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0] res_q, res_d;
  logic [XLEN-1:0] lsu_q, lsu_d;
  logic            tk_q, tk_d;
  logic [XLEN-1:0] bpc_q, bpc_d;

  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic [XLEN-1:0] rs1, rs2, imm, pc;
  logic [XLEN-1:0] op_b, pc4, pcimm, addr;
  logic [CW-1:0]   shamt;
  logic            is_lui, is_auipc, is_jal, is_jalr;
  logic            is_br, is_load, is_store;
  logic            is_opimm, is_op, is_mul;
  logic            ready, accept, br_cond, wrk;
  logic [XLEN-1:0] alu_res, res_c, bpc_c, acc_nx;
  logic            wr_c, tk_c;

  assign opc = io.opcode_in;
  assign f3  = io.funct3_in;
  assign f7  = io.funct7_in;
  assign rs1 = io.rs1_value_in;
  assign rs2 = io.rs2_value_in;
  assign imm = io.imm_value_in;
  assign pc  = io.pc_in;

  assign is_lui   = (opc == OPC_LUI);
  assign is_auipc = (opc == OPC_AUIPC);
  assign is_jal   = (opc == OPC_JAL);
  assign is_jalr  = (opc == OPC_JALR);
  assign is_br    = (opc == OPC_BR);
  assign is_load  = (opc == OPC_LOAD);
  assign is_store = (opc == OPC_STORE);
  assign is_opimm = (opc == OPC_OPIMM);
  assign is_op    = (opc == OPC_OP);
  assign is_mul   = MUL_EN && is_op &&
                    (f7 == 7'b0000001) &&
                    (f3 == 3'b000);

  assign op_b  = is_op ? rs2 : imm;
  assign shamt = op_b[CW-1:0];
  assign pc4   = pc + XLEN'(4);
  assign pcimm = pc + imm;
  assign addr  = rs1 + imm;

  assign ready  = (state_q == S_IDLE) && !io.stall_in &&
                  !io.flush_in && !rst;
  assign accept = io.valid_in && ready;
  assign acc_nx = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    alu_res = '0;
    case (f3)
      3'b000: alu_res = (is_op && f7[5]) ? rs1 - op_b
                                         : rs1 + op_b;
      3'b001: alu_res = rs1 << shamt;
      3'b010: alu_res = XLEN'($signed(rs1) < $signed(op_b));
      3'b011: alu_res = XLEN'(rs1 < op_b);
      3'b100: alu_res = rs1 ^ op_b;
      3'b101: alu_res = f7[5] ? XLEN'($signed(rs1) >>> shamt)
                              : rs1 >> shamt;
      3'b110: alu_res = rs1 | op_b;
      default: alu_res = rs1 & op_b;
    endcase
  end

  always_comb begin
    br_cond = 1'b0;
    case (f3)
      3'b000: br_cond = (rs1 == rs2);
      3'b001: br_cond = (rs1 != rs2);
      3'b100: br_cond = ($signed(rs1) < $signed(rs2));
      3'b101: br_cond = ($signed(rs1) >= $signed(rs2));
      3'b110: br_cond = (rs1 < rs2);
      3'b111: br_cond = (rs1 >= rs2);
      default: br_cond = 1'b0;
    endcase
  end

  // bpc defaults to fall-through so a not-taken branch reads pc+4
  always_comb begin
    res_c = '0;
    wrk   = 1'b0;
    tk_c  = 1'b0;
    bpc_c = pc4;
    unique case (1'b1)
      is_lui: begin
        res_c = imm;
        wrk   = 1'b1;
      end
      is_auipc: begin
        res_c = pcimm;
        wrk   = 1'b1;
      end
      is_jal: begin
        res_c = pc4;
        wrk   = 1'b1;
        tk_c  = 1'b1;
        bpc_c = pcimm;
      end
      is_jalr: begin
        res_c = pc4;
        wrk   = 1'b1;
        tk_c  = 1'b1;
        bpc_c = {addr[XLEN-1:1], 1'b0};
      end
      is_br: begin
        tk_c  = br_cond;
        bpc_c = br_cond ? pcimm : pc4;
      end
      is_load: begin
        res_c = addr;
        wrk   = 1'b1;
      end
      is_store: res_c = addr;
      is_op, is_opimm: begin
        res_c = alu_res;
        wrk   = 1'b1;
      end
      default: ;
    endcase
  end

  assign wr_c = wrk && (io.rd_in != '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    valid_d  = valid_q;
    wr_d     = wr_q;
    rd_d     = rd_q;
    res_d    = res_q;
    lsu_d    = lsu_q;
    tk_d     = tk_q;
    bpc_d    = bpc_q;
    if (io.flush_in) begin
      valid_d = 1'b0;
      wr_d    = 1'b0;
      tk_d    = 1'b0;
      state_d = S_IDLE;
    end else if (!io.stall_in) begin
      valid_d = 1'b0;
      wr_d    = 1'b0;
      tk_d    = 1'b0;
      if (state_q == S_MUL) begin
        acc_d    = acc_nx;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          res_d   = acc_nx;
          valid_d = 1'b1;
          wr_d    = (rd_q != '0);
          state_d = S_IDLE;
        end
      end else if (accept) begin
        rd_d = io.rd_in;
        if (is_mul) begin
          mcand_d  = rs1;
          mplier_d = rs2;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = S_MUL;
        end else begin
          valid_d = 1'b1;
          wr_d    = wr_c;
          res_d   = res_c;
          lsu_d   = addr;
          tk_d    = tk_c;
          bpc_d   = bpc_c;
        end
      end
    end
  end

  always_ff @(posedge req) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      valid_q  <= 1'b0;
      wr_q     <= 1'b0;
      rd_q     <= '0;
      res_q    <= '0;
      lsu_q    <= '0;
      tk_q     <= 1'b0;
      bpc_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      valid_q  <= valid_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      res_q    <= res_d;
      lsu_q    <= lsu_d;
      tk_q     <= tk_d;
      bpc_q    <= bpc_d;
    end
  end

  assign io.ready_out        = ready;
  assign io.busy_out         = (state_q == S_MUL);
  assign io.valid_out        = valid_q;
  assign io.rd_write         = wr_q;
  assign io.rd_out           = rd_q;
  assign io.result_out       = res_q;
  assign io.lsu_addr_out     = lsu_q;
  assign io.branch_taken_out = tk_q;
  assign io.branch_pc_out    = bpc_q;
endmodule

// File: tb/tb_execute_mc.sv
// Bench for execute_mc: 32- and 64-bit instances, vector table,
// MUL stall/flush sequences, random ops vs. behavioural model.
module tb_execute_mc;
  localparam logic [6:0] OP = 7'h33, OPI = 7'h13, LUI = 7'h37;
  localparam logic [6:0] AUI = 7'h17, JAL = 7'h6F, JALR = 7'h67;
  localparam logic [6:0] BR = 7'h63, LD = 7'h03, ST = 7'h23;
  localparam logic [63:0] M1 = 64'hFFFF_FFFF_FFFF_FFFF;

  typedef struct packed {
    logic [63:0] res, bpc, lsu;
    logic wr, tk, cres, cbpc, clsu;
  } exp_t;

  typedef struct {
    logic [6:0] op; logic [2:0] f3; logic [6:0] f7;
    logic [63:0] rs1, rs2, imm, pc; logic [4:0] rd;
    logic [63:0] r32, r64; logic wr, tk;
    logic [63:0] bpc; logic cres;
  } vec_t;

  logic clk = 0, rst = 1, stall = 0, flush = 0;
  logic va = 0, vb = 0;
  logic [6:0] op = 0, f7 = 0;
  logic [2:0] f3 = 0;
  logic [63:0] rs1 = 0, rs2 = 0, imm = 0, pc = 0;
  logic [4:0] rd = 0;
  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  execute_mc_if #(.XLEN(32), .RA_W(5)) ifa ();
  execute_mc_if #(.XLEN(64), .RA_W(5)) ifb ();

  assign ifa.stall_in = stall;       assign ifb.stall_in = stall;
  assign ifa.flush_in = flush;       assign ifb.flush_in = flush;
  assign ifa.valid_in = va;          assign ifb.valid_in = vb;
  assign ifa.opcode_in = op;         assign ifb.opcode_in = op;
  assign ifa.funct3_in = f3;         assign ifb.funct3_in = f3;
  assign ifa.funct7_in = f7;         assign ifb.funct7_in = f7;
  assign ifa.rs1_value_in = rs1[31:0]; assign ifb.rs1_value_in = rs1;
  assign ifa.rs2_value_in = rs2[31:0]; assign ifb.rs2_value_in = rs2;
  assign ifa.imm_value_in = imm[31:0]; assign ifb.imm_value_in = imm;
  assign ifa.pc_in = pc[31:0];       assign ifb.pc_in = pc;
  assign ifa.rd_in = rd;             assign ifb.rd_in = rd;

  execute_mc #(.XLEN(32), .MUL_EN(1'b1), .RA_W(5)) dut_a (
    .req(clk), .rst(rst), .io(ifa));
  execute_mc #(.XLEN(64), .MUL_EN(1'b1), .RA_W(5)) dut_b (
    .req(clk), .rst(rst), .io(ifb));

  task automatic chk(input string nm, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic exp_t model(input int xl, input logic [6:0] o,
      input logic [2:0] f, input logic [6:0] g,
      input logic [63:0] a0, b0, i0, p0, input logic [4:0] r);
    exp_t e;
    logic [63:0] m, a, b, i, p, sb;
    int sh;
    bit t, wk;
    m = (xl == 64) ? M1 : 64'h0000_0000_FFFF_FFFF;
    a = (xl == 64) ? a0 : {{32{a0[31]}}, a0[31:0]};
    b = (xl == 64) ? b0 : {{32{b0[31]}}, b0[31:0]};
    i = (xl == 64) ? i0 : {{32{i0[31]}}, i0[31:0]};
    p = (xl == 64) ? p0 : {{32{p0[31]}}, p0[31:0]};
    e = '0;
    e.cres = 1;
    wk = 0;
    case (o)
      LUI: begin e.res = i; wk = 1; end
      AUI: begin e.res = p + i; wk = 1; end
      JAL: begin
        e.res = p + 4; wk = 1; e.tk = 1; e.bpc = p + i; e.cbpc = 1;
      end
      JALR: begin
        e.res = p + 4; wk = 1; e.tk = 1; e.cbpc = 1;
        e.bpc = (a + i) & ~64'd1;
      end
      BR: begin
        case (f)
          3'd0: t = (a == b);
          3'd1: t = (a != b);
          3'd4: t = ($signed(a) < $signed(b));
          3'd5: t = ($signed(a) >= $signed(b));
          3'd6: t = ((a & m) < (b & m));
          3'd7: t = ((a & m) >= (b & m));
          default: t = 0;
        endcase
        e.tk = t; e.cbpc = 1; e.cres = 0;
        e.bpc = t ? p + i : p + 4;
      end
      LD, ST: begin
        e.res = a + i; e.lsu = a + i; e.clsu = 1; wk = (o == LD);
      end
      OP, OPI: begin
        wk = 1;
        sb = (o == OP) ? b : i;
        sh = int'(sb[5:0]) & (xl - 1);
        if (o == OP && g == 7'd1 && f == 3'd0) e.res = a * sb;
        else case (f)
          3'd0: e.res = (o == OP && g[5]) ? a - sb : a + sb;
          3'd1: e.res = a << sh;
          3'd2: e.res = {63'd0, $signed(a) < $signed(sb)};
          3'd3: e.res = {63'd0, (a & m) < (sb & m)};
          3'd4: e.res = a ^ sb;
          3'd5: e.res = g[5] ? 64'($signed(a) >>> sh) : (a & m) >> sh;
          3'd6: e.res = a | sb;
          default: e.res = a & sb;
        endcase
      end
      default: e.res = 0;
    endcase
    e.wr = wk && (r != 0);
    e.res &= m; e.bpc &= m; e.lsu &= m;
    return e;
  endfunction

  task automatic check_out(input string tag, input bit w64,
                           input exp_t e, input logic [4:0] rdx);
    logic v, wr, tk;
    logic [4:0] ro;
    logic [63:0] res, bpc, lsu;
    if (w64) begin
      v = ifb.valid_out; wr = ifb.rd_write; tk = ifb.branch_taken_out;
      ro = ifb.rd_out; res = ifb.result_out;
      bpc = ifb.branch_pc_out; lsu = ifb.lsu_addr_out;
    end else begin
      v = ifa.valid_out; wr = ifa.rd_write; tk = ifa.branch_taken_out;
      ro = ifa.rd_out; res = 64'(ifa.result_out);
      bpc = 64'(ifa.branch_pc_out); lsu = 64'(ifa.lsu_addr_out);
    end
    chk({tag, "/valid"}, v, 1);
    chk({tag, "/rd_write"}, wr, e.wr);
    chk({tag, "/rd_out"}, ro, rdx);
    chk({tag, "/taken"}, tk, e.tk);
    if (e.cres) chk({tag, "/result"}, res, e.res);
    if (e.cbpc) chk({tag, "/bpc"}, bpc, e.bpc);
    if (e.clsu) chk({tag, "/lsu"}, lsu, e.lsu);
  endtask

  task automatic issue(input logic [6:0] o, input logic [2:0] f,
      input logic [6:0] g, input logic [63:0] a, b, i, p,
      input logic [4:0] r, input bit en_b);
    op = o; f3 = f; f7 = g; rs1 = a; rs2 = b; imm = i; pc = p; rd = r;
    va = 1; vb = en_b;
    #1;
    chk("ready32", ifa.ready_out, 1);
    if (en_b) chk("ready64", ifb.ready_out, 1);
    @(posedge clk); #1;
  endtask

  task automatic single(input string tag, input logic [6:0] o,
      input logic [2:0] f, input logic [6:0] g,
      input logic [63:0] a, b, i, p, input logic [4:0] r);
    issue(o, f, g, a, b, i, p, r, 1);
    check_out({tag, "32"}, 0, model(32, o, f, g, a, b, i, p, r), r);
    check_out({tag, "64"}, 1, model(64, o, f, g, a, b, i, p, r), r);
  endtask

  task automatic mul_run(input logic [63:0] a, b, input logic [4:0] r,
      input int stall_at, input int stall_len, input bit both);
    exp_t ea, eb;
    int ns, sc;
    bit da, db;
    ea = model(32, OP, 0, 7'd1, a, b, 0, 0, r);
    eb = model(64, OP, 0, 7'd1, a, b, 0, 0, r);
    issue(OP, 3'd0, 7'd1, a, b, 0, 0, r, both);
    va = 0; vb = 0;
    chk("mul32 accept valid", ifa.valid_out, 0);
    ns = 0; sc = 0; da = 0; db = !both;
    for (int e = 0; e < 64 + stall_len + 4 && !(da && db); e++) begin
      stall = (ns == stall_at && sc < stall_len);
      if (!da) chk("mul32 ready", ifa.ready_out, 0);
      @(posedge clk); #1;
      if (stall) sc++; else ns++;
      if (!da) begin
        if (ifa.valid_out) begin
          da = 1;
          chk("mul32 latency", ns, 32);
          chk("mul32 result", 64'(ifa.result_out), ea.res);
          chk("mul32 rd_write", ifa.rd_write, ea.wr);
        end else chk("mul32 busy", ifa.busy_out, 1);
      end
      if (!db) begin
        if (ifb.valid_out) begin
          db = 1;
          chk("mul64 latency", ns, 64);
          chk("mul64 result", ifb.result_out, eb.res);
        end else chk("mul64 busy", ifb.busy_out, 1);
      end
    end
    stall = 0;
    chk("mul32 done", da, 1);
    chk("mul64 done", db, 1);
    @(posedge clk); #1;
    chk("mul32 pulse", ifa.valid_out, 0);
    chk("mul32 idle", ifa.busy_out, 0);
  endtask

  function automatic logic [63:0] rnd64();
    logic [63:0] v;
    v = {$urandom, $urandom};
    if ($urandom_range(0, 3) == 0) v = 64'($urandom_range(0, 70));
    return v;
  endfunction

  vec_t tbl[18];
  logic [6:0] rops[9];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{OP, 0, 0, 5, 7, 0, 0, 3, 12, 12, 1, 0, 0, 1};
    tbl[1]  = '{OP, 0, 7'h20, 5, 7, 0, 0, 4,
                64'hFFFFFFFE, 64'hFFFFFFFFFFFFFFFE, 1, 0, 0, 1};
    tbl[2]  = '{OPI, 0, 0, 1, 0, 2, 0, 0, 3, 3, 0, 0, 0, 1};
    tbl[3]  = '{OP, 5, 7'h20, 64'h80000000, 31, 0, 0, 5,
                64'hFFFFFFFF, 1, 1, 0, 0, 1};
    tbl[4]  = '{OP, 1, 0, 1, 40, 0, 0, 6,
                64'h100, 64'h100_0000_0000, 1, 0, 0, 1};
    tbl[5]  = '{OP, 3, 0, M1, 1, 0, 0, 7, 0, 0, 1, 0, 0, 1};
    tbl[6]  = '{OP, 2, 0, M1, 1, 0, 0, 8, 1, 1, 1, 0, 0, 1};
    tbl[7]  = '{LUI, 0, 0, 0, 0, 64'h12345000, 0, 9,
                64'h12345000, 64'h12345000, 1, 0, 0, 1};
    tbl[8]  = '{AUI, 0, 0, 0, 0, 64'h1000, 64'h100, 10,
                64'h1100, 64'h1100, 1, 0, 0, 1};
    tbl[9]  = '{LD, 2, 0, 64'h1000, 0, 64'h10, 0, 11,
                64'h1010, 64'h1010, 1, 0, 0, 1};
    tbl[10] = '{ST, 2, 0, 64'h1000, 0, 64'h10, 0, 12,
                64'h1010, 64'h1010, 0, 0, 0, 1};
    tbl[11] = '{BR, 0, 0, 9, 9, 64'h20, 64'h100, 13,
                0, 0, 0, 1, 64'h120, 0};
    tbl[12] = '{JALR, 0, 0, 64'h203, 0, 0, 64'h100, 1,
                64'h104, 64'h104, 1, 1, 64'h202, 1};
    tbl[13] = '{JAL, 0, 0, 0, 0, 64'h40, 64'h200, 2,
                64'h204, 64'h204, 1, 1, 64'h240, 1};
    tbl[14] = '{OPI, 4, 0, 64'hF0, 0, M1, 0, 14,
                64'hFFFFFF0F, 64'hFFFFFFFFFFFFFF0F, 1, 0, 0, 1};
    tbl[15] = '{7'h7F, 0, 0, 3, 4, 5, 0, 15, 0, 0, 0, 0, 0, 1};
    tbl[16] = '{BR, 4, 0, M1, 1, 8, 64'h300, 0,
                0, 0, 0, 1, 64'h308, 0};
    tbl[17] = '{BR, 7, 0, 1, M1, 8, 64'h300, 0,
                0, 0, 0, 0, 64'h304, 0};
    rops = '{OP, OPI, LUI, AUI, JAL, JALR, BR, LD, ST};

    repeat (2) @(posedge clk);
    #1;
    chk("rst ready", ifa.ready_out, 0);
    chk("rst valid32", ifa.valid_out, 0);
    chk("rst valid64", ifb.valid_out, 0);
    chk("rst rd_write", ifa.rd_write, 0);
    chk("rst rd_out", ifa.rd_out, 0);
    chk("rst result", 64'(ifa.result_out), 0);
    chk("rst lsu", ifb.lsu_addr_out, 0);
    chk("rst taken", ifa.branch_taken_out, 0);
    chk("rst bpc", ifb.branch_pc_out, 0);
    chk("rst busy", ifb.busy_out, 0);
    rst = 0;

    single("add", OP, 0, 0, 5, 7, 0, 0, 3);
    va = 0; vb = 0;
    @(posedge clk); #1;
    chk("add pulse32", ifa.valid_out, 0);
    chk("add pulse64", ifb.valid_out, 0);
    chk("add wr drop", ifa.rd_write, 0);

    for (int k = 0; k < 18; k++) begin
      exp_t e;
      bit ctl;
      issue(tbl[k].op, tbl[k].f3, tbl[k].f7, tbl[k].rs1, tbl[k].rs2,
            tbl[k].imm, tbl[k].pc, tbl[k].rd, 1);
      ctl = (tbl[k].op == BR || tbl[k].op == JAL || tbl[k].op == JALR);
      for (int w = 0; w < 2; w++) begin
        e = '0;
        e.res = w ? tbl[k].r64 : tbl[k].r32;
        e.lsu = e.res;
        e.wr = tbl[k].wr; e.tk = tbl[k].tk; e.bpc = tbl[k].bpc;
        e.cres = tbl[k].cres; e.cbpc = ctl;
        e.clsu = (tbl[k].op == LD || tbl[k].op == ST);
        check_out($sformatf("tbl%0d_w%0d", k, w), w[0], e, tbl[k].rd);
      end
    end
    va = 0; vb = 0;
    @(posedge clk); #1;

    single("hold", OPI, 0, 0, 100, 0, 1, 0, 6);
    stall = 1;
    op = OP; f3 = 0; f7 = 0; rs1 = 1; rs2 = 1; rd = 7;
    #1;
    chk("stall ready", ifa.ready_out, 0);
    @(posedge clk); #1;
    chk("stall valid", ifa.valid_out, 1);
    chk("stall result", 64'(ifa.result_out), 101);
    stall = 0;
    @(posedge clk); #1;
    va = 0; vb = 0;
    check_out("after_stall32", 0, model(32, OP, 0, 0, 1, 1, 1, 0, 7), 7);

    mul_run(7, 6, 3, 99, 0, 0);
    mul_run(64'hFFFFFFFF, 2, 4, 99, 0, 0);
    mul_run(64'h1234, 64'h5678, 5, 12, 5, 0);

    issue(OP, 3'd0, 7'd1, 123, 456, 0, 0, 8, 0);
    va = 0;
    repeat (10) @(posedge clk);
    #1;
    flush = 1;
    @(posedge clk); #1;
    flush = 0;
    chk("flush busy", ifa.busy_out, 0);
    chk("flush valid", ifa.valid_out, 0);
    single("post_flush", OP, 0, 0, 20, 22, 0, 0, 9);
    va = 0; vb = 0;

    for (int k = 0; k < 3; k++)
      mul_run(rnd64(), rnd64(), 5'($urandom_range(0, 31)),
              $urandom_range(0, 30), $urandom_range(0, 3), 1);

    for (int k = 0; k < 150; k++) begin
      logic [6:0] o;
      logic [2:0] f;
      o = rops[$urandom_range(0, 8)];
      f = 3'($urandom_range(0, 7));
      if (o == BR && (f == 3'd2 || f == 3'd3)) f = f + 3'd2;
      single($sformatf("rnd%0d_", k), o, f,
             $urandom_range(0, 1) ? 7'h20 : 7'h00,
             rnd64(), rnd64(), rnd64(), rnd64(),
             5'($urandom_range(0, 31)));
    end
    va = 0; vb = 0;
    @(posedge clk); #1;
    chk("final pulse", ifb.valid_out, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
